// File: rtl/sig_pkg.sv
// Shared types and defaults for the lab signal chain
// (sine generator and triggered capture buffer).
package sig_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port synchronous RAM, one write port and one
// read port with a registered, enable-held output.
module capture_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      dout
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
    if (rd_en) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/sig_capture.sv
// Triggered capture buffer: waits for a rising threshold
// crossing, records 2**ADDR_WIDTH samples, replays them.
module sig_capture #(
  parameter int WIDTH      = sig_pkg::DEF_WIDTH,
  parameter int ADDR_WIDTH = sig_pkg::DEF_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] thresh,
  input  logic             arm,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  import sig_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  pv_q, pv_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [WIDTH-1:0]      ram_dout;
  logic                  trig;
  logic                  xfer;

  assign trig = en && pv_q && (prev_q < thresh)
             && (din >= thresh);
  assign xfer = rd_valid_q && rd_ready;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    pv_d       = pv_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_addr_q;
    rd_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          pv_d      = 1'b0;
          wr_addr_d = '0;
          rd_addr_d = '0;
        end
      end
      ARMED: begin
        if (en) begin
          prev_d = din;
          pv_d   = 1'b1;
        end
        if (trig) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          wr_addr_d = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (en) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == LAST) state_d = READOUT;
        end
      end
      READOUT: begin
        // rd_addr_q is the next address to fetch; it wraps to 0
        // once the last sample is already on the output.
        if (!rd_valid_q) begin
          rd_en      = 1'b1;
          rd_addr_d  = rd_addr_q + 1'b1;
          rd_valid_d = 1'b1;
        end else if (xfer) begin
          if (rd_addr_q == '0) begin
            rd_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      pv_q       <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      pv_q       <= pv_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  capture_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .din     (din),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .dout    (ram_dout)
  );

  // RAM output is uninitialised; present zero when nothing is held.
  assign rd_data  = rd_valid_q ? ram_dout : '0;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sig_capture.sv
// Directed bench for sig_capture with a window-level reference
// model compared on every negative clock edge.
module tb_sig_capture;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] thresh = '0;
  logic         arm = 1'b0;
  logic         rd_ready = 1'b0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;
  int log_q[$];

  // model: 0 idle, 1 armed, 2 capture, 3 readout
  int m_st = 0;
  int m_prev = 0;
  bit m_pv = 0;
  int m_buf[N];
  int m_n = 0;
  int m_x = 0;
  bit m_done = 0;
  int m_wait = 0;
  bit m_seen = 0;
  bit m_stall = 0;
  int m_hold = 0;

  sig_capture #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .thresh   (thresh),
    .arm      (arm),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int lg(input int i);
    if (i < log_q.size()) return log_q[i];
    return -1;
  endfunction

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_st != 0));
    chk("done", int'(done), int'(m_done));
    if (!rd_valid) chk("rd_data_zero", int'(rd_data), 0);
    if (m_st != 3) begin
      chk("rd_valid_off", int'(rd_valid), 0);
    end else if (!m_seen) begin
      m_wait++;
      if (m_wait >= 2) chk("rd_valid_lat", int'(rd_valid), 1);
      if (rd_valid) m_seen = 1;
    end
    if (m_stall) begin
      chk("hold_valid", int'(rd_valid), 1);
      chk("hold_data", int'(rd_data), m_hold);
    end
    if (rd_valid && rd_ready && !rst) begin
      chk("rd_data", int'(rd_data), (m_x < N) ? m_buf[m_x] : -1);
      log_q.push_back(int'(rd_data));
    end
    m_hold = int'(rd_data);
    m_done = 0;
    if (rst) begin
      m_st = 0;
      m_stall = 0;
    end else begin
      m_stall = rd_valid && !rd_ready;
      case (m_st)
        0: if (arm) begin m_st = 1; m_pv = 0; end
        1: if (en) begin
          if (m_pv && m_prev < int'(thresh)
              && int'(din) >= int'(thresh)) begin
            m_buf[0] = int'(din);
            m_n = 1;
            m_st = 2;
          end
          m_prev = int'(din);
          m_pv = 1;
        end
        2: if (en) begin
          m_buf[m_n] = int'(din);
          m_n++;
          if (m_n == N) begin
            m_st = 3; m_x = 0; m_wait = 0; m_seen = 0;
          end
        end
        3: if (rd_valid && rd_ready) begin
          m_x++;
          if (m_x == N) begin m_st = 0; m_done = 1; end
        end
        default: m_st = 0;
      endcase
    end
  end

  task automatic step(input logic e, input int d,
                      input logic a, input logic r);
    @(posedge clk);
    #1;
    en = e;
    din = W'(d);
    arm = a;
    rd_ready = r;
  endtask

  task automatic wait_done(input int mode);
    int i;
    bit seen;
    seen = 0;
    for (i = 0; i < 200 && !seen; i++) begin
      step(1'b0, 0, 1'b0, (mode == 0) || (i % 3 == 0));
      if (done) seen = 1;
    end
    chk("done_seen", int'(seen), 1);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // ramp 120,124,...; first crossing is 124 -> 128
    thresh = 8'd128;
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 18; k++) step(1'b1, 120 + 4*k, 1'b0, 1'b1);
    wait_done(0);
    chk("t1_count", log_q.size(), 16);
    chk("t1_first", lg(0), 128);
    chk("t1_last", lg(15), 188);

    // first sample after arming cannot trigger
    thresh = 8'd100;
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 200, 1'b0, 1'b1);
    step(1'b1, 50, 1'b0, 1'b1);
    step(1'b1, 100, 1'b0, 1'b1);
    for (int k = 1; k < 16; k++) step(1'b1, 100 + k, 1'b0, 1'b1);
    wait_done(0);
    chk("t2_first", lg(0), 100);
    chk("t2_second", lg(1), 101);

    // backpressure during readout
    thresh = 8'd10;
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b1, 20 + k, 1'b0, 1'b0);
    wait_done(1);
    chk("t3_count", log_q.size(), 16);
    for (int k = 0; k < 16; k++) chk("t3_order", lg(k), 20 + k);

    // en stall mid-window
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 0, 1'b0, 1'b1);
    for (int c = 0; c <= 20; c++)
      step(!(c >= 6 && c <= 10), 20 + c, 1'b0, 1'b1);
    wait_done(0);
    chk("t4_pre", lg(5), 25);
    chk("t4_post", lg(6), 31);
    chk("t4_last", lg(15), 40);

    // arm ignored while busy; reset mid-readout
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) step(1'b1, 60 + c, c == 5, 1'b0);
    for (int i = 0; i < 50 && log_q.size() < 3; i++)
      step(1'b0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_xfers", log_q.size(), 3);
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(rd_valid), 0);
    chk("t5_done", int'(done), 0);
    log_q.delete();
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 0, 1'b0, 1'b1);
    for (int c = 0; c < 16; c++) step(1'b1, 90 + c, 1'b0, 1'b1);
    wait_done(0);
    chk("t5_rearm_first", lg(0), 90);
    chk("t5_rearm_last", lg(15), 105);

    // level then falling input never triggers
    thresh = 8'd100;
    step(1'b0, 0, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b1, 200, 1'b0, 1'b1);
    for (int c = 199; c >= 150; c--) step(1'b1, c, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t6_busy", int'(busy), 1);
    chk("t6_valid", int'(rd_valid), 0);
    rst = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_capture.md
Name: sig_capture

Overview:
- Receive-side counterpart to the sine generator: takes a sampled waveform stream (e.g. the generator's dout) and waits for a rising threshold crossing.
- On the crossing, records a fixed window of 2**ADDR_WIDTH samples into an internal RAM.
- Replays the window over a valid/ready read port.
- Sits downstream of the generator in the lab signal chain, as a triggered scope-style capture buffer.

Parameters:
- WIDTH, 8, sample width in bits (unsigned samples).
- ADDR_WIDTH, 8, capture buffer address width; window length N = 2**ADDR_WIDTH samples.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; din is consumed only on cycles with en=1.
- din  input  WIDTH  incoming sample.
- thresh  input  WIDTH  trigger level, unsigned.
- arm  input  1  single-cycle request to start a capture; honoured only in IDLE.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds a buffered sample.
- rd_data  output  WIDTH  buffered sample, oldest (trigger sample) first.
- busy  output  1  high in ARMED, CAPTURE or READOUT.
- done  output  1  one-cycle pulse after the final sample is transferred.

Behaviour:
- Reset: state=IDLE; rd_valid=0, rd_data=0, busy=0, done=0; write/read addresses=0; prev-sample-valid flag cleared. RAM contents are not reset.
- States: IDLE, ARMED, CAPTURE, READOUT. The state register holds a value from the package enum.
- IDLE:
  - arm=1 -> ARMED next cycle; prev-sample-valid cleared.
  - All other inputs are ignored.
- ARMED:
  - Each en cycle registers din as prev and sets prev-sample-valid.
  - Trigger condition: en=1, prev-sample-valid=1, prev < thresh and din >= thresh.
  - din == thresh counts as a crossing. prev == thresh does not arm a crossing.
  - Consequence: the first en sample after arming can never trigger.
  - On trigger: din is written to address 0 in the same cycle, write address becomes 1, state -> CAPTURE.
- CAPTURE:
  - Each en=1 cycle writes din to the write address, then increments it.
  - en=0 stalls: no write, address held.
  - The write of address N-1 moves the state to READOUT; the write address wraps to 0.
  - No trigger evaluation in this state.
- READOUT:
  - Samples are presented in address order 0..N-1.
  - rd_valid rises at most 2 cycles after entering READOUT (RAM read latency 1).
  - Transfer occurs on rd_valid && rd_ready.
  - While rd_valid && !rd_ready, rd_data and rd_valid hold stable.
  - Back-to-back transfers: with rd_ready held high, one sample per cycle after the first.
  - After the transfer of address N-1: rd_valid=0, done=1 for exactly one cycle, state -> IDLE.
  - en, din and arm are ignored.
- busy = (state != IDLE), registered, same-cycle as state.
- arm asserted while busy is dropped; it is not queued.
- rst at any point, including mid-capture or mid-readout, returns to reset values next edge; any partial window is discarded.
- Address counters are ADDR_WIDTH bits and wrap modulo N. Comparisons are unsigned, WIDTH bits. No saturation is needed.

Decomposition:
- Package sig_pkg holds:
  - the state enum typedef (IDLE, ARMED, CAPTURE, READOUT);
  - default WIDTH/ADDR_WIDTH localparams shared with the sine generator top.
- One sub-module: capture_ram, a simple dual-port synchronous RAM.
  - Write port: clk, wr_en, wr_addr, din.
  - Read port: rd_en, rd_addr, dout; registered output, 1-cycle latency.
  - Parameterised by WIDTH and ADDR_WIDTH.
- The FSM, trigger compare, address counters and output skid/hold logic live in sig_capture.

Test Plan:
- Trigger and replay: ADDR_WIDTH=4, thresh=128, en=1 continuous, din ramps 120,124,...; arm once. Triggers on 120->124? No: first crossing is 124->128, so 128 is stored at address 0. Readout with rd_ready=1 yields 128,132,...,188 (16 values), then a done pulse; busy low the following cycle.
- First-sample guard: arm, then the first en sample is din=200 with thresh=100 -> no trigger. Then din=50, din=100 -> trigger on 100, which is stored first.
- Backpressure: during readout, toggle rd_ready 1,0,0,1,... -> rd_data stable while rd_ready=0. Exactly 16 transfers in order, no duplicates or skips.
- en stall in CAPTURE: drop en for 5 cycles mid-window -> the replayed sequence contains only en-qualified samples, contiguous with no gaps or repeats.
- Ignored arm / mid-op reset: pulse arm during CAPTURE -> no effect. Assert rst during READOUT after 3 transfers -> next cycle state IDLE, rd_valid=0, busy=0, no done pulse. A fresh arm then works normally.
- Falling or level input: din constant 200 with thresh=100, then a descending ramp -> no trigger; stays ARMED with busy=1 indefinitely.
